// File: rtl/mips_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS32 control unit:
//   - opcode values carried in IR[31:26]
//   - ALU-control operation codes
//   - alu_src_b and pc_source mux encodings
//   - FSM state encoding (4 bits)
//   - packed control word produced by the state decoder
// No ports (package only).
// ----------------------------------------------------------------------------
package mips_ctrl_pkg;

    // Supported opcodes. They occupy 0..7 contiguously, so "defined" means
    // "no larger than OP_J".
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_SW    = 6'd1;
    localparam logic [5:0] OP_LW    = 6'd2;
    localparam logic [5:0] OP_ADDI  = 6'd3;
    localparam logic [5:0] OP_ANDI  = 6'd4;
    localparam logic [5:0] OP_ORI   = 6'd5;
    localparam logic [5:0] OP_BEQ   = 6'd6;
    localparam logic [5:0] OP_J     = 6'd7;

    // ALU-control operation codes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;

    // ALU operand B select
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_I_EXEC   = 4'd8,
        S_ALU_WB   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_ERROR    = 4'd12
    } state_t;

    // Registered part of the control word. ir_write and the fetch PC load
    // are not here: they are qualified by mem_ready in the top.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dest;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] aluop;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// ----------------------------------------------------------------------------
// mc_ctrl_decode
// Pure combinational decode of an FSM state (plus opcode where the state
// needs it) into the datapath control word.
// Ports:
//   state_i     in  state_t   state to decode (the FSM's next state)
//   opcode_i    in  OP_W      IR opcode field
//   ctrl_o      out ctrl_t    control word for that state
//   op_valid_o  out 1         opcode is one of the supported instructions
// ----------------------------------------------------------------------------
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  state_t            state_i,
    input  logic [OP_W-1:0]   opcode_i,
    output ctrl_t             ctrl_o,
    output logic              op_valid_o
);

    // Supported opcodes are contiguous from zero.
    assign op_valid_o = (opcode_i <= OP_W'(OP_J));

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                // PC + 4 computed while the instruction is read
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.i_or_d    = 1'b0;
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.aluop     = ALU_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                // Speculative branch target: PC + (sext imm << 2)
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.aluop     = ALU_ADD;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.aluop     = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_dest   = 1'b0;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.aluop     = ALU_FUNCT;
            end
            S_I_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                if (opcode_i == OP_W'(OP_ANDI)) begin
                    ctrl_o.aluop = ALU_AND;
                end else if (opcode_i == OP_W'(OP_ORI)) begin
                    ctrl_o.aluop = ALU_OR;
                end else begin
                    ctrl_o.aluop = ALU_ADD;
                end
            end
            S_ALU_WB: begin
                // R-type writes rd, immediate forms write rt
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.reg_dest   = (opcode_i == OP_W'(OP_RTYPE));
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_RT;
                ctrl_o.aluop         = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            default: begin
                // IDLE and ERROR drive everything low
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Multi-cycle MIPS32 control unit. Moore FSM sequencing FETCH / DECODE /
// EXEC / MEM / WB over a shared memory port, with a mem_ready wait-state
// handshake, a wait-state timeout into a sticky bus error, and an ERROR
// state that is left only through reset.
//
// Control outputs are registered: every edge loads the decode of the next
// state. ir_write and the fetch PC load are the exception: they are the
// FETCH state qualified by mem_ready, so IR/PC only move on a completed
// fetch. instr_done in MEM_WR is likewise qualified by mem_ready.
//
// Build option: define ILLEGAL_OP_TRAP_EN to send undefined opcodes to
// ERROR with sticky illegal_op. Without it an undefined opcode retires as
// a NOP in DECODE and illegal_op is tied low.
//
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   en                 run enable, sampled in IDLE and at instruction end
//   opcode             IR[31:26], valid from DECODE onward
//   mem_ready          memory completes the access this cycle
//   pc_write           unconditional PC load
//   pc_write_cond      PC load if ALU zero
//   pc_source          00 ALU result, 01 ALUOut, 10 jump target
//   i_or_d             memory address: 0 PC, 1 ALUOut
//   mem_read/mem_write memory requests
//   ir_write           IR load
//   reg_dest           1 rd, 0 rt
//   mem_to_reg         1 MDR, 0 ALUOut
//   reg_write          register file write
//   alu_src_a          0 PC, 1 rs
//   alu_src_b          00 rt, 01 4, 10 sext imm, 11 sext imm<<2
//   aluop              ALU-control operation
//   instr_done         one-cycle pulse in the final state of an instruction
//   bus_err            sticky memory timeout
//   illegal_op         sticky undefined opcode (trap build only)
// ----------------------------------------------------------------------------
module multicycle_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_source,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dest,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] aluop,
    output logic               instr_done,
    output logic               bus_err,
    output logic               illegal_op
);

    // Counter value seen on the last tolerated wait cycle
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       bus_err_q, bus_err_d;
    logic       illegal_q, illegal_d;
    logic       op_valid;
    logic       in_wait;
    logic       timeout;
    state_t     end_next;

    mc_ctrl_decode #(
        .OP_W (OP_W)
    ) u_decode (
        .state_i    (state_d),
        .opcode_i   (opcode),
        .ctrl_o     (ctrl_d),
        .op_valid_o (op_valid)
    );

    // A wait cycle is any memory-access state whose access has not completed.
    // mem_ready on the last tolerated cycle completes the access instead of
    // raising the timeout.
    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR);
    assign timeout = in_wait && !mem_ready && (wait_q == WAIT_LAST);

    // ------------------------------------------------------------------
    // State / counter / flag / control-word register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            ctrl_q    <= '0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            ctrl_q    <= ctrl_d;
            bus_err_q <= bus_err_d;
            illegal_q <= illegal_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, wait counter and sticky flags
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        end_next = en ? S_FETCH : S_IDLE;

        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready)    state_d = S_DECODE;
                else if (timeout) state_d = S_ERROR;
            end
            S_DECODE: begin
                case (opcode)
                    OP_W'(OP_RTYPE): state_d = S_R_EXEC;
                    OP_W'(OP_SW),
                    OP_W'(OP_LW):    state_d = S_MEM_ADDR;
                    OP_W'(OP_ADDI),
                    OP_W'(OP_ANDI),
                    OP_W'(OP_ORI):   state_d = S_I_EXEC;
                    OP_W'(OP_BEQ):   state_d = S_BRANCH;
                    OP_W'(OP_J):     state_d = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:         state_d = S_ERROR;
`else
                    // Undefined opcode retires here as a NOP
                    default:         state_d = end_next;
`endif
                endcase
            end
            S_MEM_ADDR: begin
                state_d = (opcode == OP_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                if (mem_ready)    state_d = S_MEM_WB;
                else if (timeout) state_d = S_ERROR;
            end
            S_MEM_WR: begin
                if (mem_ready)    state_d = end_next;
                else if (timeout) state_d = S_ERROR;
            end
            S_R_EXEC,
            S_I_EXEC: begin
                state_d = S_ALU_WB;
            end
            S_MEM_WB,
            S_ALU_WB,
            S_BRANCH,
            S_JUMP: begin
                state_d = end_next;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Counts only while stalled in the same access; any completion,
        // exit or timeout clears it.
        if (in_wait && !mem_ready && !timeout) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = '0;
        end

        bus_err_d = bus_err_q | timeout;

`ifdef ILLEGAL_OP_TRAP_EN
        illegal_d = illegal_q | ((state_q == S_DECODE) && !op_valid);
`else
        illegal_d = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // Outputs: registered control word plus mem_ready-qualified strobes
    // ------------------------------------------------------------------
    always_comb begin
        ir_write      = (state_q == S_FETCH) && mem_ready;
        pc_write      = ctrl_q.pc_write | ir_write;
        pc_write_cond = ctrl_q.pc_write_cond;
        pc_source     = ctrl_q.pc_source;
        i_or_d        = ctrl_q.i_or_d;
        mem_read      = ctrl_q.mem_read;
        mem_write     = ctrl_q.mem_write;
        reg_dest      = ctrl_q.reg_dest;
        mem_to_reg    = ctrl_q.mem_to_reg;
        reg_write     = ctrl_q.reg_write;
        alu_src_a     = ctrl_q.alu_src_a;
        alu_src_b     = ctrl_q.alu_src_b;
        aluop         = ALUOP_W'(ctrl_q.aluop);
        bus_err       = bus_err_q;
`ifdef ILLEGAL_OP_TRAP_EN
        illegal_op    = illegal_q;
        instr_done    = ctrl_q.instr_done |
                        ((state_q == S_MEM_WR) && mem_ready);
`else
        // illegal_q is held low in this build
        illegal_op    = illegal_q;
        instr_done    = ctrl_q.instr_done |
                        ((state_q == S_MEM_WR) && mem_ready) |
                        ((state_q == S_DECODE) && !op_valid);
`endif
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
// Directed bench for multicycle_ctrl_fsm. All outputs are packed into one
// 20-bit observation word and compared against hand-written constants:
//   [19] pc_write [18] pc_write_cond [17:16] pc_source [15] i_or_d
//   [14] mem_read [13] mem_write [12] ir_write [11] reg_dest
//   [10] mem_to_reg [9] reg_write [8] alu_src_a [7:6] alu_src_b
//   [5:3] aluop [2] instr_done [1] bus_err [0] illegal_op
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dest, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] pc_source, alu_src_b;
    logic [2:0] aluop;
    logic       instr_done, bus_err, illegal_op;

    logic [19:0] obs;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [19:0] E_ZERO       = 20'h00000;
    localparam logic [19:0] E_FETCH_RDY  = 20'b1_0_00_0_1_0_1_0_0_0_0_01_000_0_0_0;
    localparam logic [19:0] E_FETCH_WAIT = 20'b0_0_00_0_1_0_0_0_0_0_0_01_000_0_0_0;
    localparam logic [19:0] E_DECODE     = 20'b0_0_00_0_0_0_0_0_0_0_0_11_000_0_0_0;
    localparam logic [19:0] E_DECODE_NOP = 20'b0_0_00_0_0_0_0_0_0_0_0_11_000_1_0_0;
    localparam logic [19:0] E_REXEC      = 20'b0_0_00_0_0_0_0_0_0_0_1_00_010_0_0_0;
    localparam logic [19:0] E_ALUWB_R    = 20'b0_0_00_0_0_0_0_1_0_1_0_00_000_1_0_0;
    localparam logic [19:0] E_MEMADDR    = 20'b0_0_00_0_0_0_0_0_0_0_1_10_000_0_0_0;
    localparam logic [19:0] E_MEMRD      = 20'b0_0_00_1_1_0_0_0_0_0_0_00_000_0_0_0;
    localparam logic [19:0] E_MEMWB      = 20'b0_0_00_0_0_0_0_0_1_1_0_00_000_1_0_0;
    localparam logic [19:0] E_BRANCH     = 20'b0_1_01_0_0_0_0_0_0_0_1_00_001_1_0_0;
    localparam logic [19:0] E_JUMP       = 20'b1_0_10_0_0_0_0_0_0_0_0_00_000_1_0_0;
    localparam logic [19:0] E_IEXEC_AND  = 20'b0_0_00_0_0_0_0_0_0_0_1_10_011_0_0_0;
    localparam logic [19:0] E_ALUWB_I    = 20'b0_0_00_0_0_0_0_0_0_1_0_00_000_1_0_0;
    localparam logic [19:0] E_MEMWR_WAIT = 20'b0_0_00_1_0_1_0_0_0_0_0_00_000_0_0_0;
    localparam logic [19:0] E_MEMWR_DONE = 20'b0_0_00_1_0_1_0_0_0_0_0_00_000_1_0_0;
    localparam logic [19:0] E_BUSERR     = 20'h00002;
    localparam logic [19:0] E_ILLEGAL    = 20'h00001;

    multicycle_ctrl_fsm #(
        .OP_W        (6),
        .ALUOP_W     (3),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dest      (reg_dest),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .aluop         (aluop),
        .instr_done    (instr_done),
        .bus_err       (bus_err),
        .illegal_op    (illegal_op)
    );

    always #5 clk = ~clk;

    assign obs = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
                  mem_write, ir_write, reg_dest, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, aluop, instr_done, bus_err, illegal_op};

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [19:0] observed,
                       input logic [19:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %05h expected %05h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        opcode    = 6'd0;
        mem_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        smp(); chk("reset", obs, E_ZERO);
        nxt(); rst_n = 1'b1;
        smp(); chk("idle_en0", obs, E_ZERO);

        // R-type, mem_ready=1: IDLE, FETCH, DECODE, R_EXEC, ALU_WB
        nxt(); en = 1'b1; opcode = 6'd0; mem_ready = 1'b1;
        smp(); chk("r_idle", obs, E_ZERO);
        nxt(); smp(); chk("r_fetch", obs, E_FETCH_RDY);
        nxt(); smp(); chk("r_decode", obs, E_DECODE);
        nxt(); smp(); chk("r_exec", obs, E_REXEC);
        nxt(); smp(); chk("r_alu_wb", obs, E_ALUWB_R);

        // lw with three MEM_RD wait cycles: 8 cycles FETCH..MEM_WB
        nxt(); opcode = 6'd2;
        smp(); chk("lw_fetch", obs, E_FETCH_RDY);
        nxt(); smp(); chk("lw_decode", obs, E_DECODE);
        nxt(); mem_ready = 1'b0;
        smp(); chk("lw_mem_addr", obs, E_MEMADDR);
        for (int i = 0; i < 3; i++) begin
            nxt(); smp(); chk("lw_rd_wait", obs, E_MEMRD);
        end
        nxt(); mem_ready = 1'b1;
        smp(); chk("lw_rd_done", obs, E_MEMRD);
        nxt(); en = 1'b0;
        smp(); chk("lw_mem_wb", obs, E_MEMWB);

        // en=0 at instruction end returns to IDLE with no mem_read
        nxt(); en = 1'b1; opcode = 6'd6;
        smp(); chk("end_to_idle", obs, E_ZERO);

        // beq: 3 cycles
        nxt(); smp(); chk("beq_fetch", obs, E_FETCH_RDY);
        nxt(); smp(); chk("beq_decode", obs, E_DECODE);
        nxt(); smp(); chk("beq_branch", obs, E_BRANCH);

        // j: 3 cycles
        nxt(); opcode = 6'd7;
        smp(); chk("j_fetch", obs, E_FETCH_RDY);
        nxt(); smp(); chk("j_decode", obs, E_DECODE);
        nxt(); smp(); chk("j_jump", obs, E_JUMP);

        // andi with one fetch wait cycle: no IR/PC load until ready
        nxt(); opcode = 6'd4; mem_ready = 1'b0;
        smp(); chk("andi_fetch_wait", obs, E_FETCH_WAIT);
        nxt(); mem_ready = 1'b1;
        smp(); chk("andi_fetch", obs, E_FETCH_RDY);
        nxt(); smp(); chk("andi_decode", obs, E_DECODE);
        nxt(); smp(); chk("andi_exec", obs, E_IEXEC_AND);
        nxt(); smp(); chk("andi_alu_wb", obs, E_ALUWB_I);

        // sw completing immediately
        nxt(); opcode = 6'd1;
        smp(); chk("sw_fetch", obs, E_FETCH_RDY);
        nxt(); smp(); chk("sw_decode", obs, E_DECODE);
        nxt(); smp(); chk("sw_mem_addr", obs, E_MEMADDR);
        nxt(); smp(); chk("sw_wr_done", obs, E_MEMWR_DONE);

        // sw stalled in MEM_WR, then reset mid-wait
        nxt(); smp(); chk("sw2_fetch", obs, E_FETCH_RDY);
        nxt(); smp(); chk("sw2_decode", obs, E_DECODE);
        nxt(); smp(); chk("sw2_mem_addr", obs, E_MEMADDR);
        nxt(); mem_ready = 1'b0;
        smp(); chk("sw2_wr_wait", obs, E_MEMWR_WAIT);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_write", obs, E_ZERO);
        nxt(); rst_n = 1'b1; en = 1'b0; mem_ready = 1'b1;
        smp(); chk("post_rst", obs, E_ZERO);
        nxt(); smp(); chk("post_rst_hold", obs, E_ZERO);

        // Undefined opcode 6'h3F
        nxt(); en = 1'b1; opcode = 6'h3F;
        smp(); chk("ill_idle", obs, E_ZERO);
        nxt(); smp(); chk("ill_fetch", obs, E_FETCH_RDY);
`ifdef ILLEGAL_OP_TRAP_EN
        nxt(); smp(); chk("ill_decode", obs, E_DECODE);
        nxt(); smp(); chk("ill_error", obs, E_ILLEGAL);
        nxt(); smp(); chk("ill_error_hold", obs, E_ILLEGAL);
`else
        nxt(); smp(); chk("nop_decode", obs, E_DECODE_NOP);
        nxt(); opcode = 6'd0;
        smp(); chk("nop_next_fetch", obs, E_FETCH_RDY);
`endif

        // Reset, then mem_ready arriving on the 15th wait cycle wins
        nxt(); rst_n = 1'b0; en = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
        smp(); chk("rst2", obs, E_ZERO);
        nxt(); rst_n = 1'b1; en = 1'b1;
        smp(); chk("rdy_idle", obs, E_ZERO);
        nxt(); smp(); chk("rdy_wait_c1", obs, E_FETCH_WAIT);
        for (int i = 2; i <= 14; i++) begin
            nxt();
        end
        nxt(); mem_ready = 1'b1;
        smp(); chk("rdy_wins_c15", obs, E_FETCH_RDY);
        nxt(); smp(); chk("rdy_decode", obs, E_DECODE);

        // Reset, then 15 stalled fetch cycles -> ERROR with bus_err
        nxt(); rst_n = 1'b0; mem_ready = 1'b0;
        smp(); chk("rst3", obs, E_ZERO);
        nxt(); rst_n = 1'b1;
        smp(); chk("tmo_idle", obs, E_ZERO);
        nxt(); smp(); chk("tmo_c1", obs, E_FETCH_WAIT);
        for (int i = 2; i <= 14; i++) begin
            nxt();
        end
        nxt(); smp(); chk("tmo_c15", obs, E_FETCH_WAIT);
        nxt(); mem_ready = 1'b1;
        smp(); chk("tmo_error", obs, E_BUSERR);
        repeat (3) nxt();
        smp(); chk("tmo_error_hold", obs, E_BUSERR);

        // Only reset leaves ERROR and clears the sticky flag
        nxt(); rst_n = 1'b0;
        #1 chk("err_rst", obs, E_ZERO);
        nxt(); rst_n = 1'b1; en = 1'b0;
        smp(); chk("err_rst_idle", obs, E_ZERO);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
